// File: rtl/fifo_pkg.sv
// Shared definitions for the Gray-pointer packet FIFO controllers.
//   state_t     : controller sequencing states
//   gray2bin    : Gray -> binary, zero-extended to PTR_MAX_W
//   bin2gray    : binary -> Gray, zero-extended to PTR_MAX_W
//   ptr_is_full : write/read Gray pointers differ by exactly one full lap
package fifo_pkg;

  // Widest pointer the helpers handle; callers zero-extend narrower pointers.
  localparam int unsigned PTR_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT0 = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // Prefix-XOR from the MSB down; leading zeros of a zero-extended value stay zero.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] i_gray);
    logic [PTR_MAX_W-1:0] w_bin;
    w_bin = i_gray;
    for (int s = 1; s < int'(PTR_MAX_W); s = s * 2) begin
      w_bin = w_bin ^ (w_bin >> s);
    end
    return w_bin;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] i_bin);
    return i_bin ^ (i_bin >> 1);
  endfunction

  // A full lap in Gray code: top two bits of the pw-bit pointer inverted, rest equal.
  function automatic logic ptr_is_full(input logic [PTR_MAX_W-1:0] i_wr_gray,
                                       input logic [PTR_MAX_W-1:0] i_rd_gray,
                                       input int unsigned          i_pw);
    logic [PTR_MAX_W-1:0] w_flip;
    w_flip = PTR_MAX_W'(3) << (i_pw - 2);
    return i_wr_gray == (i_rd_gray ^ w_flip);
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_gray_counter.sv
// GrayCounter: Gray-coded pointer with synchronous clear and count enable.
// No reset: contents are undefined until the first Clear_in.
//   Clk                  in  clock
//   Clear_in             in  synchronous clear to 0
//   Enable_in            in  advance by one
//   GrayCount_out        out current count (Gray)
//   GrayCountPlusOne_out out current count + 1 (Gray)
module GrayCounter
  import fifo_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 5
) (
  input  logic                     Clk,
  input  logic                     Clear_in,
  input  logic                     Enable_in,
  output logic [COUNTER_WIDTH-1:0] GrayCount_out,
  output logic [COUNTER_WIDTH-1:0] GrayCountPlusOne_out
);

  logic [COUNTER_WIDTH-1:0] r_gray;
  logic [COUNTER_WIDTH-1:0] r_gray_p1;
  logic [COUNTER_WIDTH-1:0] w_bin_p2;
  logic [COUNTER_WIDTH-1:0] w_gray_p2;

  // Look-ahead value; truncate before Gray encoding so the wrap is clean.
  always_comb begin
    w_bin_p2  = COUNTER_WIDTH'(gray2bin(PTR_MAX_W'(r_gray_p1)) + PTR_MAX_W'(1));
    w_gray_p2 = COUNTER_WIDTH'(bin2gray(PTR_MAX_W'(w_bin_p2)));
  end

  // Both count and count+1 are held in flops so neither output is a long adder path.
  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      r_gray    <= '0;
      r_gray_p1 <= COUNTER_WIDTH'(1);
    end else if (Enable_in) begin
      r_gray    <= r_gray_p1;
      r_gray_p1 <= w_gray_p2;
    end
  end

  assign GrayCount_out        = r_gray;
  assign GrayCountPlusOne_out = r_gray_p1;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller of the Gray-pointer packet FIFO.
// Sequences the write GrayCounter, drives the RAM write port, exports the Gray
// write pointer and derives Full/AlmostFull against the synchronised read pointer.
//   Clk            in  clock
//   Reset_in       in  asynchronous active-high reset
//   Flush_in       in  discard contents and restart pointers at 0
//   WrReq_in       in  write request
//   RdPtrGray_in   in  read pointer (Gray), already in Clk domain
//   WrEn_out       out RAM write strobe, same cycle as an accepted request
//   WrAddr_out     out RAM write address
//   WrPtrGray_out  out write pointer (Gray) towards read domain
//   Full_out       out registered full flag
//   AlmostFull_out out registered occupancy >= AFULL_LEVEL
//   Ready_out      out registered, controller running
//   Overflow_out   out sticky, a request was refused while running
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                  Clk,
  input  logic                  Reset_in,
  input  logic                  Flush_in,
  input  logic                  WrReq_in,
  input  logic [ADDR_WIDTH:0]   RdPtrGray_in,
  output logic                  WrEn_out,
  output logic [ADDR_WIDTH-1:0] WrAddr_out,
  output logic [ADDR_WIDTH:0]   WrPtrGray_out,
  output logic                  Full_out,
  output logic                  AlmostFull_out,
  output logic                  Ready_out,
  output logic                  Overflow_out
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_cnt_clear;
  logic          w_run;
  logic          w_accept;
  logic          w_refused;
  logic          w_full_match;
  logic          w_afull_level;
  logic [PW-1:0] w_gray;
  logic [PW-1:0] w_gray_p1;
  logic [PW-1:0] w_next_ptr;
  logic [PW-1:0] w_cur_bin;
  logic [PW-1:0] w_occupancy;
  logic          r_full;
  logic          r_afull;
  logic          r_ready;
  logic          r_overflow;

  GrayCounter #(
    .COUNTER_WIDTH(PW)
  ) u_wr_cnt (
    .Clk                 (Clk),
    .Clear_in            (w_cnt_clear),
    .Enable_in           (w_accept),
    .GrayCount_out       (w_gray),
    .GrayCountPlusOne_out(w_gray_p1)
  );

  // Next-state and counter clear; INIT and FLUSH both spend one cycle clearing.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clear  = 1'b0;
    case (r_state)
      ST_INIT, ST_FLUSH: begin
        w_cnt_clear  = 1'b1;
        w_state_next = ST_WAIT0;
      end
      ST_WAIT0: begin
        if (RdPtrGray_in == '0) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (Flush_in) w_state_next = ST_FLUSH;
      end
      default: w_state_next = ST_INIT;
    endcase
  end

  // Write acceptance and flag inputs; flush beats a same-cycle request.
  always_comb begin
    w_run         = (r_state == ST_RUN);
    w_accept      = w_run & WrReq_in & ~r_full & ~Flush_in;
    w_refused     = w_run & WrReq_in &  r_full & ~Flush_in;
    w_next_ptr    = w_accept ? w_gray_p1 : w_gray;
    w_cur_bin     = PW'(gray2bin(PTR_MAX_W'(w_gray)));
    w_occupancy   = PW'(gray2bin(PTR_MAX_W'(w_next_ptr)) - gray2bin(PTR_MAX_W'(RdPtrGray_in)));
    w_full_match  = ptr_is_full(PTR_MAX_W'(w_next_ptr), PTR_MAX_W'(RdPtrGray_in), PW);
    w_afull_level = (PTR_MAX_W'(w_occupancy) >= AFULL_LEVEL);
  end

  // State and registered flags; not-running reads as full so nothing is written.
  always_ff @(posedge Clk or posedge Reset_in) begin
    if (Reset_in) begin
      r_state    <= ST_INIT;
      r_full     <= 1'b1;
      r_afull    <= 1'b1;
      r_ready    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_full  <= (w_state_next != ST_RUN) | w_full_match;
      r_afull <= (w_state_next != ST_RUN) | w_afull_level;
      r_ready <= (w_state_next == ST_RUN);
      if (w_state_next == ST_FLUSH) begin
        r_overflow <= 1'b0;
      end else if (w_refused) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Counter is unreset, so its value is masked until the controller runs.
  assign WrEn_out       = w_accept;
  assign WrAddr_out     = w_run ? w_cur_bin[ADDR_WIDTH-1:0] : '0;
  assign WrPtrGray_out  = w_run ? w_gray : '0;
  assign Full_out       = r_full;
  assign AlmostFull_out = r_afull;
  assign Ready_out      = r_ready;
  assign Overflow_out   = r_overflow;

endmodule
